// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and press-pulse generation for left/right/select buttons.
// Define BTN_AUTOREPEAT_EN to add frame-paced auto-repeat on the left/right press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_COUNT = 250000,
  parameter int CNT_BITS       = 20,
  parameter int REPEAT_DELAY   = 30,
  parameter int REPEAT_RATE    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic frame_pulse,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_select_raw,
  output logic btn_left,
  output logic btn_right,
  output logic btn_select,
  output logic left_press,
  output logic right_press,
  output logic select_press
);
  logic [2:0] raw, s1, s2, stable, pq, done, rise, upd;
  logic [1:0] rpt;
  logic [CNT_BITS-1:0] cnt [3];
  assign raw = {btn_select_raw, btn_right_raw, btn_left_raw};
  always_comb begin
    done = '0;
    for (int i = 0; i < 3; i++) done[i] = cnt[i] == CNT_BITS'(DEBOUNCE_COUNT - 1);
    upd  = en ? (s2 ^ stable) & done : '0;
    rise = upd & s2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      pq <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      pq <= rise;
      stable <= stable ^ upd;
      if (en)
        for (int i = 0; i < 3; i++)
          cnt[i] <= (s2[i] == stable[i] || done[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  localparam int FW = $clog2(REPEAT_DELAY + 1);
  typedef enum logic {IDLE, HOLD} rep_state_t;
  rep_state_t st [2];
  rep_state_t st_n [2];
  logic [FW-1:0] fc [2];
  logic [FW-1:0] fc_n [2];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      st[i] <= rst ? IDLE : st_n[i];
      fc[i] <= rst ? '0 : fc_n[i];
    end
  end
  always_comb begin
    rpt = '0;
    for (int i = 0; i < 2; i++) begin
      st_n[i] = st[i];
      fc_n[i] = fc[i];
      if (en) begin
        if (st[i] == IDLE) begin
          st_n[i] = rise[i] ? HOLD : IDLE;
        end else if (!stable[i]) begin
          st_n[i] = IDLE;
          fc_n[i] = '0;
        end else if (frame_pulse) begin
          rpt[i]  = fc[i] == FW'(REPEAT_DELAY - 1);
          fc_n[i] = rpt[i] ? FW'(REPEAT_DELAY - REPEAT_RATE) : fc[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_rpt;
  assign rpt = '0;
  assign unused_rpt = ^{frame_pulse, REPEAT_DELAY, REPEAT_RATE};
`endif
  assign btn_left     = stable[0];
  assign btn_right    = stable[1];
  assign btn_select   = stable[2];
  assign left_press   = en & (pq[0] | rpt[0]);
  assign right_press  = en & (pq[1] | rpt[1]);
  assign select_press = en & pq[2];
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scoreboard bench for button_conditioner with DEBOUNCE_COUNT=4.
module tb_button_conditioner;
  logic clk = 0, rst = 1, en = 1, frame_pulse = 0;
  logic btn_left_raw = 0, btn_right_raw = 0, btn_select_raw = 0;
  logic btn_left, btn_right, btn_select, left_press, right_press, select_press;
  int errors = 0, checks = 0;
  typedef struct {
    logic [2:0] lv;
    logic [2:0] pr;
    string tag;
  } exp_t;
  exp_t sb[$];

  button_conditioner #(.DEBOUNCE_COUNT(4), .CNT_BITS(3), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_pulse(frame_pulse),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw), .btn_select_raw(btn_select_raw),
    .btn_left(btn_left), .btn_right(btn_right), .btn_select(btn_select),
    .left_press(left_press), .right_press(right_press), .select_press(select_press)
  );

  always #5 clk = ~clk;

  // Inputs set for a tick are captured on the posedge that ends it; the negedge check sees state after the previous edge.
  task automatic tick(input logic [2:0] lv, input logic [2:0] pr, input string tag);
    exp_t e;
    logic [2:0] got_lv, got_pr;
    sb.push_back('{lv, pr, tag});
    @(negedge clk);
    e = sb.pop_front();
    got_lv = {btn_select, btn_right, btn_left};
    got_pr = {select_press, right_press, left_press};
    checks++;
    assert (got_lv === e.lv) else begin
      errors++;
      $error("FAIL %s level got=%b exp=%b", e.tag, got_lv, e.lv);
    end
    checks++;
    assert (got_pr === e.pr) else begin
      errors++;
      $error("FAIL %s press got=%b exp=%b", e.tag, got_pr, e.pr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick(3'b000, 3'b000, "reset0");
    tick(3'b000, 3'b000, "reset1");
    rst = 0;
    btn_left_raw = 1;
    for (int k = 0; k < 10; k++) tick({2'b00, k >= 6}, {2'b00, k == 6}, "clean_press");
    btn_left_raw = 0;
    for (int k = 0; k < 8; k++) tick({2'b00, k < 6}, 3'b000, "clean_release");
    for (int k = 0; k < 16; k++) begin
      btn_select_raw = (k < 3 || k >= 6);
      tick({k >= 12, 2'b00}, {k == 12, 2'b00}, "bounce");
    end
    btn_select_raw = 0;
    for (int k = 0; k < 8; k++) tick({k < 6, 2'b00}, 3'b000, "select_release");
    for (int k = 0; k < 11; k++) begin
      btn_right_raw = k < 3;
      tick(3'b000, 3'b000, "glitch");
    end
    btn_right_raw = 1;
    for (int k = 0; k < 9; k++) tick({1'b0, k >= 6, 1'b0}, {1'b0, k == 6, 1'b0}, "right_press");
    btn_right_raw = 0;
    for (int k = 0; k < 8; k++) tick({1'b0, k < 6, 1'b0}, 3'b000, "right_release");
    btn_left_raw = 1;
    for (int k = 0; k < 20; k++) begin
      en = !(k >= 4 && k < 14);
      tick({2'b00, k >= 16}, {2'b00, k == 16}, "en_freeze");
    end
    rst = 1;
    tick(3'b001, 3'b000, "rst_assert");
    rst = 0;
    for (int k = 1; k < 10; k++) tick({2'b00, k >= 7}, {2'b00, k == 7}, "rst_recover");
    btn_left_raw = 0;
    for (int k = 0; k < 8; k++) tick({2'b00, k < 6}, 3'b000, "left_release");
    btn_left_raw = 1;
    btn_right_raw = 1;
    for (int k = 0; k < 9; k++) tick({1'b0, k >= 6, k >= 6}, {1'b0, k == 6, k == 6}, "simultaneous");
    btn_left_raw = 0;
    btn_right_raw = 0;
    for (int k = 0; k < 8; k++) tick({1'b0, k < 6, k < 6}, 3'b000, "simul_release");
`ifdef BTN_AUTOREPEAT_EN
    btn_right_raw = 1;
    for (int k = 0; k < 141; k++) begin
      frame_pulse = (k >= 16) && ((k - 16) % 20 == 0);
      tick({1'b0, k >= 6, 1'b0}, {1'b0, k == 6 || k == 56 || k == 96 || k == 136, 1'b0}, "repeat");
    end
    btn_right_raw = 0;
    for (int k = 0; k < 31; k++) begin
      frame_pulse = (k % 10 == 3);
      tick({1'b0, k < 6, 1'b0}, 3'b000, "repeat_release");
    end
    btn_right_raw = 1;
    for (int k = 0; k < 61; k++) begin
      frame_pulse = (k >= 16) && ((k - 16) % 20 == 0);
      tick({1'b0, k >= 6, 1'b0}, {1'b0, k == 6 || k == 56, 1'b0}, "repeat_restart");
    end
    frame_pulse = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
